// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding and mode constants for the serial bus ports.
package bus_pkg;
   typedef enum logic [2:0] {IDLE, REQ, ADDR, WDATA, RWAIT, RDATA, DONE} master_state_t;
   localparam logic MODE_WRITE = 1'b1;
   localparam logic MODE_READ = 1'b0;
endpackage

// File: rtl/piso_shift.sv
// piso_shift: parallel-in serial-out shifter, MSB first, zero-filled from the LSB.
module piso_shift #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb
);
   logic [W-1:0] sr;
   always_ff @(posedge clk)
      if (rst) sr <= '0;
      else if (load) sr <= din;
      else if (shift) sr <= {sr[W-2:0], 1'b0};
   assign msb = sr[W-1];
endmodule

// File: rtl/master_port.sv
// master_port: serial bus master; serialises {addr, wdata} onto wr_bus and gathers read bits from rd_bus.
module master_port
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_mode,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mode,
   output logic                  wr_bus,
   output logic                  master_valid,
   output logic                  master_ready,
   input  logic                  rd_bus,
   input  logic                  slave_ready,
   input  logic                  slave_valid
);
   localparam int BW = $clog2(ADDR_WIDTH + DATA_WIDTH + 1);
   localparam int SW = $clog2(TIMEOUT + 1);
   master_state_t state, nxt;
   logic [BW-1:0] cnt;
   logic [SW-1:0] stall;
   logic [DATA_WIDTH-1:0] cap;
   logic msb, accept, busy, tx, rx, xfer, go, last, tout;
   assign req_ready = state == IDLE;
   assign accept = req_valid && req_ready;
   assign tx = state == ADDR || state == WDATA;
   assign rx = state == RWAIT || state == RDATA;
   assign busy = state == REQ || tx || rx;
   assign xfer = (tx && slave_ready) || (rx && slave_valid);
   assign go = xfer || (state == REQ && slave_ready);
   // The bit counter runs cumulatively over address then data, so reads end at the same count as writes.
   assign last = xfer && cnt == (state == ADDR ? BW'(ADDR_WIDTH - 1) : BW'(ADDR_WIDTH + DATA_WIDTH - 1));
   assign tout = busy && !go && stall == SW'(TIMEOUT - 1);
   assign master_valid = state == REQ || tx;
   assign master_ready = rx;
   assign wr_bus = master_valid && msb;
   piso_shift #(.W(ADDR_WIDTH + DATA_WIDTH)) u_piso (
      .clk(clk),
      .rst(rst),
      .load(accept),
      .shift(tx && slave_ready),
      .din({req_addr, req_wdata}),
      .msb(msb)
   );
   always_comb begin
      nxt = state;
      if (tout) nxt = IDLE;
      else
         case (state)
            IDLE:    nxt = accept ? REQ : IDLE;
            REQ:     nxt = slave_ready ? ADDR : REQ;
            ADDR:    nxt = last ? (mode == MODE_WRITE ? WDATA : RWAIT) : ADDR;
            WDATA:   nxt = last ? DONE : WDATA;
            RWAIT:   nxt = xfer ? (last ? DONE : RDATA) : RWAIT;
            RDATA:   nxt = last ? DONE : RDATA;
            default: nxt = IDLE;
         endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         stall <= '0;
         cap <= '0;
         mode <= 1'b0;
         resp_valid <= 1'b0;
         resp_err <= 1'b0;
         resp_rdata <= '0;
      end else begin
         state <= nxt;
         cnt <= (!busy || tout) ? '0 : cnt + BW'(xfer);
         stall <= (busy && !go && !tout) ? stall + SW'(1) : '0;
         if (rx && slave_valid) cap <= {cap[DATA_WIDTH-2:0], rd_bus};
         if (accept) mode <= req_mode;
         resp_valid <= state == DONE || tout;
         resp_err <= tout;
         resp_rdata <= (state == DONE && mode == MODE_READ) ? cap : '0;
      end
endmodule
